// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the pipelined CPU datapath
// Contents: write-back destination select codes, ALU function codes,
//           architectural register indices ($zero, $ra).
package cpu_pkg;

  // Write-back destination select (id_reg_dst); 2'b11 is reserved and behaves as RT
  localparam logic [1:0] REG_DST_RT  = 2'b00;
  localparam logic [1:0] REG_DST_RD  = 2'b01;
  localparam logic [1:0] REG_DST_R31 = 2'b10;

  // ALU function codes carried through ex_alu_fn
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_SUB = 6'd1;
  localparam logic [5:0] ALU_AND = 6'd2;
  localparam logic [5:0] ALU_OR  = 6'd3;
  localparam logic [5:0] ALU_XOR = 6'd4;
  localparam logic [5:0] ALU_NOR = 6'd5;
  localparam logic [5:0] ALU_SLT = 6'd6;
  localparam logic [5:0] ALU_SLL = 6'd7;
  localparam logic [5:0] ALU_SRL = 6'd8;
  localparam logic [5:0] ALU_SRA = 6'd9;
  localparam logic [5:0] ALU_LUI = 6'd10;

  // Architectural register indices
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
// Ports: id_valid_i, id_rs_i, id_rt_i    instruction currently in ID
//        ex_valid_i, ex_mem_read_i,
//        ex_wr_reg_i                      load (if any) currently in EX
//        stall_o                          hold PC and IF/ID, bubble EX
module load_use_detect
  import cpu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_wr_reg_i,
  output logic              stall_o
);

  logic load_in_ex;
  logic src_match;

  // A load targeting $zero produces nothing a consumer could depend on.
  assign load_in_ex = ex_valid_i && ex_mem_read_i && (ex_wr_reg_i != REG_AW'(REG_ZERO));

  // rt is compared whatever the opcode: over-stalling an I-type costs one
  // cycle, decoding which instructions really read rt is not worth it here.
  assign src_match  = (ex_wr_reg_i == id_rs_i) || (ex_wr_reg_i == id_rt_i);

  assign stall_o    = id_valid_i && load_in_ex && src_match;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush
// Ports: clk, reset (async, active-low)
//        id_*      decoded instruction, register-file read data, immediate, PC+4
//        flush     branch/jump taken in EX, squash the ID instruction
//        stall_out load-use hazard, hold PC and IF/ID
//        ex_*      captured instruction for EX (ex_wr_reg already resolved)
//        bubble_cnt saturating count of flush/stall bubbles since reset
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ALU_W  = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [1:0]        id_reg_dst,
  input  logic [ALU_W-1:0]  id_alu_fn,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_wr_reg,
  output logic [ALU_W-1:0]  ex_alu_fn,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_q,     valid_d;
  logic [DATA_W-1:0] pc4_q,       pc4_d;
  logic [DATA_W-1:0] rdata1_q,    rdata1_d;
  logic [DATA_W-1:0] rdata2_q,    rdata2_d;
  logic [DATA_W-1:0] imm_q,       imm_d;
  logic [REG_AW-1:0] rs_q,        rs_d;
  logic [REG_AW-1:0] rt_q,        rt_d;
  logic [REG_AW-1:0] wr_reg_q,    wr_reg_d;
  logic [ALU_W-1:0]  alu_fn_q,    alu_fn_d;
  logic              alu_src_q,   alu_src_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic              stall;
  logic              forced_bubble;
  logic              bubble;
  logic [REG_AW-1:0] wr_sel;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (mem_read_q),
    .ex_wr_reg_i   (wr_reg_q),
    .stall_o       (stall)
  );

  // Destination resolved here so EX/MEM/WB only ever see a final index.
  always_comb begin
    wr_sel = id_rt;
    if (id_reg_dst == REG_DST_RD) begin
      wr_sel = id_rd;
    end else if (id_reg_dst == REG_DST_R31) begin
      wr_sel = REG_AW'(REG_RA);
    end
  end

  // Flush and stall both produce the same bubble, so their priority only
  // matters for the counter: one bubble per edge, counted once.
  assign forced_bubble = flush || stall;
  assign bubble        = forced_bubble || !id_valid;

  always_comb begin
    pc4_d        = id_pc4;
    rdata1_d     = id_rdata1;
    rdata2_d     = id_rdata2;
    imm_d        = id_imm;
    rs_d         = id_rs;
    rt_d         = id_rt;
    alu_fn_d     = id_alu_fn;
    alu_src_d    = id_alu_src;
    valid_d      = 1'b1;
    wr_reg_d     = wr_sel;
    reg_write_d  = id_reg_write;
    mem_read_d   = id_mem_read;
    mem_write_d  = id_mem_write;
    mem_to_reg_d = id_mem_to_reg;
    if (bubble) begin
      valid_d      = 1'b0;
      wr_reg_d     = '0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (forced_bubble && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      pc4_q        <= '0;
      rdata1_q     <= '0;
      rdata2_q     <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      wr_reg_q     <= '0;
      alu_fn_q     <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      pc4_q        <= pc4_d;
      rdata1_q     <= rdata1_d;
      rdata2_q     <= rdata2_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      wr_reg_q     <= wr_reg_d;
      alu_fn_q     <= alu_fn_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      cnt_q        <= cnt_d;
    end
  end

  assign stall_out     = stall;
  assign ex_valid      = valid_q;
  assign ex_pc4        = pc4_q;
  assign ex_rdata1     = rdata1_q;
  assign ex_rdata2     = rdata2_q;
  assign ex_imm        = imm_q;
  assign ex_rs         = rs_q;
  assign ex_rt         = rt_q;
  assign ex_wr_reg     = wr_reg_q;
  assign ex_alu_fn     = alu_fn_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc4, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_reg_dst;
  logic [5:0]  id_alu_fn;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush;
  logic        stall_out, ex_valid;
  logic [31:0] ex_pc4, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_wr_reg;
  logic [5:0]  ex_alu_fn;
  logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [15:0] bubble_cnt;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc4(id_pc4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_reg_dst(id_reg_dst), .id_alu_fn(id_alu_fn), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush), .stall_out(stall_out), .ex_valid(ex_valid),
    .ex_pc4(ex_pc4), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wr_reg(ex_wr_reg),
    .ex_alu_fn(ex_alu_fn), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what EX should hold, as a plain record of the last instruction accepted.
  bit          m_valid, m_rw, m_mr, m_mw, m_mtr, m_alu_src;
  logic [4:0]  m_wr, m_rs, m_rt;
  logic [5:0]  m_alu_fn;
  logic [31:0] m_pc4, m_rd1, m_rd2, m_imm;
  int          m_cnt;

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0; m_wr = 0; m_cnt = 0;
  endtask

  function automatic bit model_stall();
    return id_valid && m_valid && m_mr && (m_wr != 0) && (m_wr == id_rs || m_wr == id_rt);
  endfunction

  function automatic logic [4:0] dest_of(input logic [1:0] sel, input logic [4:0] rt, input logic [4:0] rd);
    case (sel)
      2'b01:   return rd;
      2'b10:   return 5'd31;
      default: return rt;
    endcase
  endfunction

  // One pipeline cycle: check stall before the edge, advance model, check EX after it.
  task automatic cycle();
    bit st;
    #1;
    st = model_stall();
    check("stall_out", {31'b0, stall_out}, {31'b0, st});
    @(posedge clk);
    if (flush || st) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_wr = 0;
      if (m_cnt < 65535) m_cnt++;
    end else if (!id_valid) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_wr = 0;
    end else begin
      m_valid = 1; m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
      m_mtr = id_mem_to_reg; m_wr = dest_of(id_reg_dst, id_rt, id_rd);
      m_rs = id_rs; m_rt = id_rt; m_alu_fn = id_alu_fn; m_alu_src = id_alu_src;
      m_pc4 = id_pc4; m_rd1 = id_rdata1; m_rd2 = id_rdata2; m_imm = id_imm;
    end
    #1;
    check("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
    check("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m_rw});
    check("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m_mr});
    check("ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m_mw});
    check("ex_wr_reg", {27'b0, ex_wr_reg}, {27'b0, m_wr});
    check("bubble_cnt", {16'b0, bubble_cnt}, m_cnt[31:0]);
    if (m_valid) begin
      check("ex_mem_to_reg", {31'b0, ex_mem_to_reg}, {31'b0, m_mtr});
      check("ex_rs", {27'b0, ex_rs}, {27'b0, m_rs});
      check("ex_rt", {27'b0, ex_rt}, {27'b0, m_rt});
      check("ex_alu_fn", {26'b0, ex_alu_fn}, {26'b0, m_alu_fn});
      check("ex_alu_src", {31'b0, ex_alu_src}, {31'b0, m_alu_src});
      check("ex_pc4", ex_pc4, m_pc4);
      check("ex_rdata1", ex_rdata1, m_rd1);
      check("ex_rdata2", ex_rdata2, m_rd2);
      check("ex_imm", ex_imm, m_imm);
    end
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [1:0] dst, input bit rw, input bit mr);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_reg_dst = dst;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = 0; id_mem_to_reg = mr;
    id_alu_fn = ALU_ADD; id_alu_src = mr;
    id_pc4 = $urandom; id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
  endtask

  task automatic randomize_inputs();
    id_valid = ($urandom_range(0, 7) != 0);
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3)); id_reg_dst = 2'($urandom_range(0, 3));
    id_alu_fn = 6'($urandom_range(0, 10)); id_alu_src = 1'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) != 0);
    id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    id_pc4 = $urandom; id_rdata1 = $urandom; id_rdata2 = $urandom; id_imm = $urandom;
    flush = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    reset = 0; flush = 0;
    set_instr(5'd1, 5'd2, 5'd3, 2'b01, 1, 0);
    model_reset();
    #12;
    check("reset_valid", {31'b0, ex_valid}, 32'd0);
    check("reset_cnt", {16'b0, bubble_cnt}, 32'd0);
    check("reset_stall", {31'b0, stall_out}, 32'd0);
    reset = 1;
    @(posedge clk); #1;

    // Normal R-type capture
    set_instr(5'd3, 5'd4, 5'd9, 2'b01, 1, 0);
    id_rdata1 = 32'h12345678;
    cycle();
    check("norm_rdata1", ex_rdata1, 32'h12345678);
    check("norm_wr_reg", {27'b0, ex_wr_reg}, 32'd9);

    // Load-use: lw to r8, then consumer of r8 stalls exactly one cycle
    set_instr(5'd1, 5'd8, 5'd0, 2'b00, 1, 1);
    cycle();
    set_instr(5'd8, 5'd2, 5'd4, 2'b01, 1, 0);
    #1 check("lu_stall_hi", {31'b0, stall_out}, 32'd1);
    cycle();
    check("lu_bubble", {31'b0, ex_valid}, 32'd0);
    check("lu_cnt", {16'b0, bubble_cnt}, 32'd1);
    check("lu_stall_lo", {31'b0, stall_out}, 32'd0);
    cycle();
    check("lu_held_cap", {27'b0, ex_wr_reg}, 32'd4);

    // Load to $zero never stalls
    set_instr(5'd1, 5'd0, 5'd0, 2'b00, 1, 1);
    cycle();
    set_instr(5'd0, 5'd0, 5'd5, 2'b01, 1, 0);
    cycle();
    check("zero_cnt", {16'b0, bubble_cnt}, 32'd1);

    // Flush together with a stall counts one bubble; then jal writes r31
    set_instr(5'd1, 5'd8, 5'd0, 2'b00, 1, 1);
    cycle();
    set_instr(5'd8, 5'd8, 5'd6, 2'b01, 1, 0);
    flush = 1;
    cycle();
    check("fs_cnt", {16'b0, bubble_cnt}, 32'd2);
    flush = 0;
    set_instr(5'd0, 5'd0, 5'd0, 2'b10, 1, 0);
    cycle();
    check("jal_wr_reg", {27'b0, ex_wr_reg}, 32'd31);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      cycle();
    end

    // Asynchronous reset mid-cycle while a load-use stall is pending
    flush = 0;
    set_instr(5'd1, 5'd7, 5'd0, 2'b00, 1, 1);
    cycle();
    set_instr(5'd7, 5'd2, 5'd3, 2'b01, 1, 0);
    #2 reset = 0;
    #1;
    model_reset();
    check("mid_rst_valid", {31'b0, ex_valid}, 32'd0);
    check("mid_rst_mr", {31'b0, ex_mem_read}, 32'd0);
    check("mid_rst_wr", {27'b0, ex_wr_reg}, 32'd0);
    check("mid_rst_rdata1", ex_rdata1, 32'd0);
    check("mid_rst_pc4", ex_pc4, 32'd0);
    check("mid_rst_cnt", {16'b0, bubble_cnt}, 32'd0);
    check("mid_rst_stall", {31'b0, stall_out}, 32'd0);
    @(posedge clk); #1;
    check("rst_hold_valid", {31'b0, ex_valid}, 32'd0);
    reset = 1;
    cycle();

    // Counter saturation under continuous flush
    flush = 1;
    m_cnt = 0;
    check("sat_start", {16'b0, bubble_cnt}, 32'd0);
    repeat (65534) @(posedge clk);
    #1 check("sat_pre", {16'b0, bubble_cnt}, 32'd65534);
    repeat (7) @(posedge clk);
    #1 check("sat_top", {16'b0, bubble_cnt}, 32'hFFFF);
    check("sat_valid", {31'b0, ex_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
